// File: rtl/iter_controller_if.sv
// Handshake and strobe bundle between the iteration controller and its surroundings.
interface iter_controller_if;
  logic start;
  logic carryout;
  logic initcnt;
  logic encnt;
  logic ldx;
  logic initacc;
  logic ldterm;
  logic ldacc;
  logic ready;
  logic done;
  logic err;

  // Top level / counter side: drives start and carryout, observes the strobes.
  modport master (
    output start, carryout,
    input  initcnt, encnt, ldx, initacc, ldterm, ldacc, ready, done, err
  );

  // Controller side.
  modport slave (
    input  start, carryout,
    output initcnt, encnt, ldx, initacc, ldterm, ldacc, ready, done, err
  );
endinterface

// File: rtl/iter_controller.sv
// Moore sequencer for an iterative datapath: one init, then TERM/ACC/CHECK
// rounds until the counter wraps or MAXITER rounds elapse (timeout -> err).
module iter_controller #(
  parameter int unsigned MAXITER = 8
) (
  input  logic              clk,
  input  logic              rst,
  iter_controller_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_INIT  = 3'd2,
    S_TERM  = 3'd3,
    S_ACC   = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   iter_q;
  logic               err_q;
  logic               at_limit;

  logic initcnt_c, encnt_c, ldx_c, initacc_c, ldterm_c, ldacc_c, ready_c, done_c;

  assign at_limit = (iter_q == CNT_W'(MAXITER));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Iteration count and timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          iter_q <= '0;
          err_q  <= 1'b0;
        end
        S_ACC:   iter_q <= iter_q + CNT_W'(1);
        S_CHECK: if (!bus.carryout && at_limit) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = bus.start ? S_ARMED : S_IDLE;
      S_ARMED: state_d = bus.start ? S_ARMED : S_INIT;
      S_INIT:  state_d = S_TERM;
      S_TERM:  state_d = S_ACC;
      S_ACC:   state_d = S_CHECK;
      S_CHECK: state_d = (bus.carryout || at_limit) ? S_DONE : S_TERM;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode from the state register alone.
  always_comb begin
    initcnt_c = 1'b0;
    encnt_c   = 1'b0;
    ldx_c     = 1'b0;
    initacc_c = 1'b0;
    ldterm_c  = 1'b0;
    ldacc_c   = 1'b0;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_IDLE: ready_c = 1'b1;
      S_INIT: begin
        initcnt_c = 1'b1;
        initacc_c = 1'b1;
        ldx_c     = 1'b1;
      end
      S_TERM: ldterm_c = 1'b1;
      S_ACC: begin
        ldacc_c = 1'b1;
        encnt_c = 1'b1;
      end
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.initcnt = initcnt_c;
  assign bus.encnt   = encnt_c;
  assign bus.ldx     = ldx_c;
  assign bus.initacc = initacc_c;
  assign bus.ldterm  = ldterm_c;
  assign bus.ldacc   = ldacc_c;
  assign bus.ready   = ready_c;
  assign bus.done    = done_c;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_iter_controller.sv
// Randomized bench for iter_controller against a run-level model of iterations,
// strobe totals, latencies and the err flag.
module tb_iter_controller;

  localparam int unsigned MAXITER = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  iter_controller_if bus ();

  iter_controller #(.MAXITER(MAXITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Edge counter and strobe tallies observed mid-cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t_init = 0, t_enc = 0, t_term = 0, t_acc = 0, t_ldx = 0, t_iacc = 0;
  int t_done = 0, t_overlap = 0;
  int init_cyc = 0, done_cyc = 0;

  // Counter block model: carryout rises after the co_k-th encnt since initcnt (0 = never).
  int co_k = 0;
  int mcnt = 0;
  int mcnt_nxt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      mcnt_nxt = 0;
    end else begin
      if (bus.initcnt) begin t_init++; init_cyc = cyc; end
      if (bus.encnt)   t_enc++;
      if (bus.ldterm)  t_term++;
      if (bus.ldacc)   t_acc++;
      if (bus.ldx)     t_ldx++;
      if (bus.initacc) t_iacc++;
      if (bus.done)    begin t_done++; done_cyc = cyc; end
      if (bus.initcnt && bus.encnt) t_overlap++;
      if (bus.initcnt)    mcnt_nxt = 0;
      else if (bus.encnt) mcnt_nxt = mcnt + 1;
      else                mcnt_nxt = mcnt;
    end
  end

  always @(posedge clk) begin
    #1;
    mcnt = mcnt_nxt;
    bus.carryout = (co_k != 0 && mcnt >= co_k);
  end

  logic last_err = 1'b0;

  task automatic do_run(input int k, input int hold, input bit busy);
    int  n;
    logic exp_err;
    int  s_init, s_enc, s_term, s_acc, s_ldx, s_iacc, s_done, s_ovl;
    int  e0;
    bit  seen, term_chk;

    exp_err = (k >= 1 && k <= int'(MAXITER)) ? 1'b0 : 1'b1;
    n       = exp_err ? int'(MAXITER) : k;
    co_k    = k;

    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.ready === 1'b1);
    end
    check("idle_ready", 32'(seen), 1);

    s_init = t_init; s_enc = t_enc; s_term = t_term; s_acc = t_acc;
    s_ldx = t_ldx; s_iacc = t_iacc; s_done = t_done; s_ovl = t_overlap;

    bus.start = 1'b1;
    @(negedge clk);
    e0 = cyc;
    check("armed_ready", 32'(bus.ready), 0);
    check("armed_err", 32'(bus.err), 32'(last_err));
    for (int i = 1; i < hold; i++) @(negedge clk);
    check("armed_quiet", 32'({bus.initcnt, bus.encnt, bus.ldx, bus.initacc,
                              bus.ldterm, bus.ldacc, bus.done, bus.ready}), 0);
    bus.start = 1'b0;

    seen = 0;
    term_chk = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.ldterm && !term_chk) begin
        check("err_cleared", 32'(bus.err), 0);
        term_chk = 1;
      end
      seen = bus.done;
      if (busy && !seen) bus.start = 1'($urandom_range(0, 1));
      else               bus.start = 1'b0;
    end
    check("done_seen", 32'(seen), 1);
    check("done_err", 32'(bus.err), 32'(exp_err));

    @(negedge clk);
    check("idle_after", 32'(bus.ready), 1);
    check("idle_err", 32'(bus.err), 32'(exp_err));

    check("n_encnt",   t_enc - s_enc,   n);
    check("n_ldterm",  t_term - s_term, n);
    check("n_ldacc",   t_acc - s_acc,   n);
    check("n_initcnt", t_init - s_init, 1);
    check("n_ldx",     t_ldx - s_ldx,   1);
    check("n_initacc", t_iacc - s_iacc, 1);
    check("n_done",    t_done - s_done, 1);
    check("overlap",   t_overlap - s_ovl, 0);
    check("init_lat",  init_cyc - e0, hold);
    check("done_lat",  done_cyc - init_cyc, 1 + 3 * n);
    last_err = exp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s_done;
    bit seen;
    int encs;

    bus.start = 1'b0;
    #3;
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_outs", 32'({bus.initcnt, bus.encnt, bus.ldx, bus.initacc,
                           bus.ldterm, bus.ldacc, bus.done, bus.err}), 0);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hold_ready", 32'(bus.ready), 1);
    bus.start = 1'b0;
    rst = 1'b1;

    do_run(8, 1, 0);
    do_run(0, 1, 0);
    repeat (5) @(negedge clk);
    check("err_held_idle", 32'(bus.err), 1);
    do_run(3, 1, 0);
    do_run(8, 5, 0);
    do_run(8, 2, 1);
    do_run(9, 1, 1);
    do_run(1, 1, 0);
    for (int r = 0; r < 8; r++)
      do_run(int'($urandom_range(0, 12)), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));

    // Abort during ACC with an asynchronous reset, then a clean run.
    co_k = 8;
    s_done = t_done;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    encs = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.encnt) encs++;
      seen = (encs == 2);
    end
    check("abort_reach_acc", 32'(seen), 1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_encnt", 32'(bus.encnt), 0);
    check("abort_ready", 32'(bus.ready), 1);
    check("abort_done", 32'(bus.done), 0);
    check("abort_err", 32'(bus.err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("abort_no_done", t_done - s_done, 0);
    last_err = 1'b0;
    do_run(8, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
